// File: rtl/wb_b3_slave_mem.sv
// Wishbone B3 classic-cycle memory slave with tag storage, byte lanes and wait states.
// Define WB_SLAVE_MEM_ADR_ERR_EN to terminate out-of-range requests with err_o.
module wb_b3_slave_mem #(
  parameter int unsigned DAT_W    = 64,
  parameter int unsigned ADR_W    = 8,
  parameter int unsigned TAG_W    = 1,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [ADR_W-1:0]   adr_i,
  input  logic [DAT_W-1:0]   dat_i,
  output logic [DAT_W-1:0]   dat_o,
  input  logic [DAT_W/8-1:0] sel_i,
  input  logic               we_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               lock_i,
  input  logic [TAG_W-1:0]   tga_i,
  input  logic [TAG_W-1:0]   tgc_i,
  input  logic [TAG_W-1:0]   tgd_i,
  output logic [TAG_W-1:0]   tgd_o,
  output logic               ack_o,
  output logic               err_o,
  output logic               rty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SEL_W = DAT_W / 8;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               err_d;
  logic [DAT_W-1:0]   dat_q;
  logic [TAG_W-1:0]   tgd_q;
  logic               req;
  logic               exec;
  logic               addr_ok;
  logic               wr_en;
  logic               rd_en;
  logic [IDX_W-1:0]   idx;

  logic [DAT_W-1:0]   mem  [DEPTH];
  logic [TAG_W-1:0]   tmem [DEPTH];

  assign req = cyc_i & stb_i;
  assign idx = adr_i[IDX_W-1:0];

`ifdef WB_SLAVE_MEM_ADR_ERR_EN
  assign addr_ok = ((adr_i >> IDX_W) == '0);
`else
  // Out-of-range addresses alias onto the low index bits.
  assign addr_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYC - 1);
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / execute logic: the transfer executes on the edge that enters StResp.
  always_comb begin
    exec  = (state_d == StResp);
    ack_d = exec & addr_ok;
    err_d = exec & ~addr_ok;
    // An edge seen while reset is asserted must never commit a write.
    wr_en = exec & addr_ok & we_i & ~rst_i;
    rd_en = exec & addr_ok & ~we_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      tgd_q <= '0;
    end else begin
      ack_q <= ack_d;
      if (rd_en) begin
        dat_q <= mem[idx];
        tgd_q <= tmem[idx];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (sel_i[i]) begin
          mem[idx][8*i +: 8] <= dat_i[8*i +: 8];
        end
      end
      if (|sel_i) begin
        tmem[idx] <= tgd_i;
      end
    end
  end

`ifdef WB_SLAVE_MEM_ADR_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ack_o = ack_q;
  assign rty_o = 1'b0;
  assign dat_o = dat_q;
  assign tgd_o = tgd_q;

  logic unused_inputs;
  assign unused_inputs = ^{lock_i, tga_i, tgc_i, adr_i, err_d};

endmodule

// File: tb/tb_wb_b3_slave_mem.sv
// Scoreboard bench for wb_b3_slave_mem: randomized transfers against an array-based memory model.
module tb_wb_b3_slave_mem;

  localparam int unsigned DAT_W    = 64;
  localparam int unsigned ADR_W    = 8;
  localparam int unsigned TAG_W    = 1;
  localparam int unsigned DEPTH    = 128;
  localparam int unsigned WAIT_CYC = 3;

`ifdef WB_SLAVE_MEM_ADR_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [ADR_W-1:0] adr_i = '0;
  logic [DAT_W-1:0] dat_i = '0;
  logic [DAT_W-1:0] dat_o;
  logic [7:0]       sel_i = '0;
  logic             we_i = 1'b0;
  logic             cyc_i = 1'b0;
  logic             stb_i = 1'b0;
  logic             lock_i = 1'b0;
  logic [TAG_W-1:0] tga_i = '0;
  logic [TAG_W-1:0] tgc_i = '0;
  logic [TAG_W-1:0] tgd_i = '0;
  logic [TAG_W-1:0] tgd_o;
  logic             ack_o;
  logic             err_o;
  logic             rty_o;

  wb_b3_slave_mem #(
    .DAT_W    (DAT_W),
    .ADR_W    (ADR_W),
    .TAG_W    (TAG_W),
    .DEPTH    (DEPTH),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk    (clk),
    .rst_i  (rst_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .sel_i  (sel_i),
    .we_i   (we_i),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .lock_i (lock_i),
    .tga_i  (tga_i),
    .tgc_i  (tgc_i),
    .tgd_i  (tgd_i),
    .tgd_o  (tgd_o),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .rty_o  (rty_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit          is_err;
    logic [63:0] dat;
    logic        tag;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          resp_cnt = 0;
  bit          prev_ack = 1'b0;

  // Reference model state
  logic [63:0] ref_mem [DEPTH];
  logic        ref_tag [DEPTH];
  logic [63:0] last_dat = '0;
  logic        last_tag = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation, including its arrival cycle.
  always @(negedge clk) begin
    if (!rst_i && (ack_o || err_o)) begin
      resp_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b cycle=%0d, expected no response",
                 ack_o, err_o, cyc_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (ack_o !== !mon_e.is_err || err_o !== mon_e.is_err || rty_o !== 1'b0 ||
            dat_o !== mon_e.dat || tgd_o !== mon_e.tag || cyc_cnt != mon_e.at ||
            (ack_o && prev_ack)) begin
          miscompares++;
          $display("FAIL resp: got ack=%0b err=%0b rty=%0b dat=%h tag=%0b cyc=%0d prev_ack=%0b expected ack=%0b err=%0b rty=0 dat=%h tag=%0b cyc=%0d prev_ack=0",
                   ack_o, err_o, rty_o, dat_o, tgd_o, cyc_cnt, prev_ack,
                   !mon_e.is_err, mon_e.is_err, mon_e.dat, mon_e.tag, mon_e.at);
        end
      end
    end
    prev_ack = ack_o;
  end

  task automatic xfer(input bit we, input logic [7:0] adr, input logic [63:0] dat,
                      input logic [7:0] sel, input logic tgd);
    exp_t        e;
    bit          got;
    int unsigned idx;
    idx      = adr % DEPTH;
    e.is_err = ErrEn && (adr >= DEPTH);
    if (!e.is_err) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (sel[i]) ref_mem[idx][8*i +: 8] = dat[8*i +: 8];
        end
        if (sel != 8'h00) ref_tag[idx] = tgd;
      end else begin
        last_dat = ref_mem[idx];
        last_tag = ref_tag[idx];
      end
    end
    e.dat = last_dat;
    e.tag = last_tag;
    @(posedge clk);
    #1;
    e.at = cyc_cnt + 1 + WAIT_CYC;
    exp_q.push_back(e);
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    we_i   = we;
    adr_i  = adr;
    dat_i  = dat;
    sel_i  = sel;
    tgd_i  = tgd;
    lock_i = 1'($urandom);
    tga_i  = 1'($urandom);
    tgc_i  = 1'($urandom);
    got    = 1'b0;
    for (int n = 0; n < int'(WAIT_CYC) + 6 && !got; n++) begin
      @(negedge clk);
      if (ack_o || err_o) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: no response for adr %h, expected one within %0d cycles",
               adr, WAIT_CYC + 6);
    end
    @(posedge clk);
    #1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
  endtask

  logic [63:0] rnd;
  logic [63:0] oor_dat;
  int          base;

  initial begin
    #1;
    check("reset_ack", 64'(ack_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    check("reset_rty", 64'(rty_o), 64'd0);
    check("reset_dat", dat_o, 64'd0);
    check("reset_tgd", 64'(tgd_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    for (int a = 0; a < int'(DEPTH); a++) begin
      xfer(1'b1, 8'(a), {$urandom, $urandom}, 8'hFF, 1'($urandom));
    end

    xfer(1'b1, 8'h10, 64'h0123456789ABCDEF, 8'hFF, 1'b1);
    xfer(1'b0, 8'h10, 64'd0, 8'hFF, 1'b0);
    check("wr_rd_dat", dat_o, 64'h0123456789ABCDEF);
    check("wr_rd_tag", 64'(tgd_o), 64'd1);

    xfer(1'b1, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    xfer(1'b1, 8'h05, 64'd0, 8'h0F, 1'b1);
    xfer(1'b0, 8'h05, 64'd0, 8'h00, 1'b0);
    check("byte_lanes", dat_o, 64'hFFFF_FFFF_0000_0000);
    check("byte_lanes_tag", 64'(tgd_o), 64'd1);
    xfer(1'b1, 8'h05, {$urandom, $urandom}, 8'h00, 1'b0);
    xfer(1'b0, 8'h05, 64'd0, 8'hFF, 1'b0);
    check("sel_zero_write", dat_o, 64'hFFFF_FFFF_0000_0000);

    // Abort: drop the strobe while still counting wait states.
    @(posedge clk);
    #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h07; sel_i = 8'hFF;
    dat_i = {$urandom, $urandom}; tgd_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    base = resp_cnt;
    repeat (WAIT_CYC + 4) @(posedge clk);
    check("abort_no_resp", 64'(resp_cnt), 64'(base));
    xfer(1'b0, 8'h07, 64'd0, 8'hFF, 1'b0);

    // Reset in the middle of a waiting write.
    xfer(1'b0, 8'h10, 64'd0, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h10; sel_i = 8'hFF;
    dat_i = 64'hDEAD_BEEF_CAFE_F00D; tgd_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_ack", 64'(ack_o), 64'd0);
    check("rst_mid_err", 64'(err_o), 64'd0);
    check("rst_mid_dat", dat_o, 64'd0);
    check("rst_mid_tgd", 64'(tgd_o), 64'd0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b0;
    last_dat = '0;
    last_tag = 1'b0;
    xfer(1'b0, 8'h10, 64'd0, 8'hFF, 1'b0);
    check("rst_no_write", dat_o, 64'h0123456789ABCDEF);

    // Out of range: errors with the feature on, aliases onto word 5 otherwise.
    oor_dat = {$urandom, $urandom};
    xfer(1'b1, 8'h85, oor_dat, 8'hFF, 1'b1);
    xfer(1'b0, 8'h05, 64'd0, 8'hFF, 1'b0);
    check("oor_alias", dat_o, ErrEn ? 64'hFFFF_FFFF_0000_0000 : oor_dat);
    xfer(1'b0, 8'h85, 64'd0, 8'hFF, 1'b0);

    for (int n = 0; n < 300; n++) begin
      rnd = {$urandom, $urandom};
      xfer(1'($urandom), 8'($urandom_range(0, 255)), rnd,
           ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
    end

    repeat (WAIT_CYC + 4) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
